// File: rtl/srl_var_delay.sv
// Multi-lane delay line with a runtime-programmable tap, valid tracking, flush and fill status.
// Optional macro SRL_VAR_DELAY_RESET_DATA_EN adds an asynchronous reset to the data stages.
module srl_var_delay #(
  parameter int unsigned C_NUM_CHANNELS = 4,
  parameter int unsigned C_DATA_WIDTH   = 32,
  parameter int unsigned C_MAX_DELAY    = 16,
  parameter int unsigned C_INIT_DELAY   = 4,
  localparam int unsigned DW            = $clog2(C_MAX_DELAY + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   ce,
  input  logic                                   flush,
  input  logic                                   delay_load,
  input  logic [DW-1:0]                          delay_in,
  input  logic                                   valid_in,
  input  logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] data_in,
  output logic                                   valid_out,
  output logic [C_NUM_CHANNELS*C_DATA_WIDTH-1:0] data_out,
  output logic [DW-1:0]                          delay_cur,
  output logic                                   primed,
  output logic                                   cfg_err
);

  localparam int unsigned   W      = C_NUM_CHANNELS * C_DATA_WIDTH;
  localparam logic [DW-1:0] MAX_D  = DW'(C_MAX_DELAY);
  localparam logic [DW-1:0] INIT_D = DW'(C_INIT_DELAY);

  logic [W-1:0]           data_sr [C_MAX_DELAY];
  logic [C_MAX_DELAY-1:0] valid_sr;
  logic [DW-1:0]          delay_q;
  logic [DW-1:0]          fill_q;
  logic                   err_q;
  logic                   clear;
  logic                   over_range;

  // A load always discards in-flight beats, exactly like a flush.
  assign clear      = flush | delay_load;
  assign over_range = (delay_in > MAX_D);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_q <= INIT_D;
      err_q   <= 1'b0;
      fill_q  <= '0;
    end else begin
      if (delay_load) begin
        delay_q <= over_range ? MAX_D : delay_in;
        if (over_range) err_q <= 1'b1;
      end
      if (clear) begin
        fill_q <= '0;
      end else if (ce && (fill_q < delay_q)) begin
        fill_q <= fill_q + 1'b1;
      end
    end
  end

  // On a clear, stage 0 still accepts the current beat when ce is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_sr <= '0;
    end else if (clear) begin
      valid_sr <= '0;
      if (ce) valid_sr[0] <= valid_in;
    end else if (ce) begin
      valid_sr[0] <= valid_in;
      for (int unsigned j = 1; j < C_MAX_DELAY; j++) begin
        valid_sr[j] <= valid_sr[j-1];
      end
    end
  end

  // Data stages shift on ce alone so that they map onto SRL primitives.
`ifdef SRL_VAR_DELAY_RESET_DATA_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < C_MAX_DELAY; j++) begin
        data_sr[j] <= '0;
      end
    end else if (ce) begin
      data_sr[0] <= data_in;
      for (int unsigned j = 1; j < C_MAX_DELAY; j++) begin
        data_sr[j] <= data_sr[j-1];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (ce) begin
      data_sr[0] <= data_in;
      for (int unsigned j = 1; j < C_MAX_DELAY; j++) begin
        data_sr[j] <= data_sr[j-1];
      end
    end
  end
`endif

  always_comb begin
    data_out  = '0;
    valid_out = 1'b0;
    if (delay_q == '0) begin
      data_out  = data_in;
      valid_out = valid_in & ce;
    end else begin
      for (int unsigned j = 0; j < C_MAX_DELAY; j++) begin
        if (delay_q == DW'(j + 1)) begin
          data_out  = data_sr[j];
          valid_out = valid_sr[j];
        end
      end
    end
  end

  assign delay_cur = delay_q;
  assign cfg_err   = err_q;
  assign primed    = (fill_q >= delay_q);

endmodule

// File: tb/tb_srl_var_delay.sv
// Directed bench for srl_var_delay at default parameters (4 lanes x 32 bits, max delay 16, init 4).
module tb_srl_var_delay;

  logic         clk;
  logic         rst_n;
  logic         ce;
  logic         flush;
  logic         delay_load;
  logic [4:0]   delay_in;
  logic         valid_in;
  logic [127:0] data_in;
  logic         valid_out;
  logic [127:0] data_out;
  logic [4:0]   delay_cur;
  logic         primed;
  logic         cfg_err;

  int checks;
  int failures;

  srl_var_delay #(
    .C_NUM_CHANNELS(4),
    .C_DATA_WIDTH  (32),
    .C_MAX_DELAY   (16),
    .C_INIT_DELAY  (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .flush     (flush),
    .delay_load(delay_load),
    .delay_in  (delay_in),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .delay_cur (delay_cur),
    .primed    (primed),
    .cfg_err   (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input int n);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) begin
      r[k*32 +: 32] = 32'(32'h100 * n + k);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] d, input logic ce_v);
    delay_in   = d;
    delay_load = 1'b1;
    ce         = ce_v;
    valid_in   = 1'b0;
    tick();
    delay_load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    ce         = 1'b0;
    flush      = 1'b0;
    delay_load = 1'b0;
    delay_in   = '0;
    valid_in   = 1'b0;
    data_in    = '0;

    // reset state
    repeat (2) tick();
    check("rst_valid", 128'(valid_out), 128'(0));
    check("rst_delay", 128'(delay_cur), 128'(4));
    check("rst_err",   128'(cfg_err),   128'(0));
    check("rst_primed", 128'(primed),   128'(0));
    rst_n = 1'b1;

    // reset latency at D=4
    for (int n = 0; n < 20; n++) begin
      ce = 1'b1; valid_in = 1'b1; data_in = pat(n);
      tick();
      check("t1_valid",  128'(valid_out), 128'(n >= 3));
      check("t1_primed", 128'(primed),    128'(n >= 3));
      if (n >= 3) check("t1_data", data_out, pat(n - 3));
    end

    // ce gating: every other cycle advances
    load(5'd4, 1'b0);
    check("t2_delay",  128'(delay_cur), 128'(4));
    check("t2_valid0", 128'(valid_out), 128'(0));
    check("t2_primed0", 128'(primed),   128'(0));
    for (int i = 0; i < 40; i++) begin
      ce = (i % 2 == 0);
      valid_in = 1'b1;
      data_in = ce ? pat(i / 2) : pat(1000 + i);
      tick();
      check("t2_valid",  128'(valid_out), 128'((i / 2) >= 3));
      check("t2_primed", 128'(primed),    128'((i / 2) >= 3));
      if ((i / 2) >= 3) check("t2_data", data_out, pat(i / 2 - 3));
    end

    // delay change 4 -> 9 at beat 10
    load(5'd4, 1'b0);
    for (int n = 0; n < 25; n++) begin
      ce = 1'b1; valid_in = 1'b1; data_in = pat(500 + n);
      if (n == 10) begin
        delay_load = 1'b1; delay_in = 5'd9;
      end
      tick();
      delay_load = 1'b0;
      if (n < 10) begin
        check("t3_delay4", 128'(delay_cur), 128'(4));
        check("t3_valid4", 128'(valid_out), 128'(n >= 3));
        if (n >= 3) check("t3_data4", data_out, pat(500 + n - 3));
      end else begin
        check("t3_delay9",  128'(delay_cur), 128'(9));
        check("t3_valid9",  128'(valid_out), 128'(n >= 18));
        check("t3_primed9", 128'(primed),    128'(n >= 19));
        if (n >= 18) check("t3_data9", data_out, pat(500 + n - 8));
      end
    end

    // maximum in-range delay
    load(5'd16, 1'b0);
    check("t4_delay16", 128'(delay_cur), 128'(16));
    check("t4_err16",   128'(cfg_err),   128'(0));
    for (int n = 0; n < 18; n++) begin
      ce = 1'b1; valid_in = (n == 0); data_in = pat(50 + n);
      tick();
      check("t4_valid16",  128'(valid_out), 128'(n == 15));
      check("t4_primed16", 128'(primed),    128'(n >= 15));
      if (n == 15) check("t4_data16", data_out, pat(50));
    end

    // out-of-range request clamps and sets sticky error
    load(5'd31, 1'b0);
    check("t4_clamp", 128'(delay_cur), 128'(16));
    check("t4_err",   128'(cfg_err),   128'(1));
    flush = 1'b1; ce = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_err_flush", 128'(cfg_err), 128'(1));

    // bypass at D=0
    load(5'd0, 1'b0);
    check("t4_delay0",  128'(delay_cur), 128'(0));
    check("t4_primed0", 128'(primed),    128'(1));
    check("t4_err_ld0", 128'(cfg_err),   128'(1));
    data_in = pat(77); valid_in = 1'b1; ce = 1'b1;
    #1;
    check("byp_data",   data_out,          pat(77));
    check("byp_valid",  128'(valid_out),   128'(1));
    ce = 1'b0;
    #1;
    check("byp_valid_ce0", 128'(valid_out), 128'(0));
    check("byp_data_ce0",  data_out,        pat(77));
    valid_in = 1'b0; ce = 1'b1;
    #1;
    check("byp_valid_vi0", 128'(valid_out), 128'(0));
    tick();
    check("byp_primed", 128'(primed), 128'(1));

    // flush with a concurrent beat at D=4
    load(5'd4, 1'b0);
    for (int n = 0; n < 12; n++) begin
      ce = 1'b1; valid_in = (n <= 5); data_in = pat(200 + n);
      flush = (n == 5);
      tick();
      flush = 1'b0;
      if (n < 5) begin
        check("t5_valid_pre", 128'(valid_out), 128'(n >= 3));
        if (n >= 3) check("t5_data_pre", data_out, pat(200 + n - 3));
      end else begin
        check("t5_valid",  128'(valid_out), 128'(n == 8));
        check("t5_primed", 128'(primed),    128'(n >= 9));
        if (n == 8) check("t5_data", data_out, pat(205));
      end
    end
    check("t5_err", 128'(cfg_err), 128'(1));

    // asynchronous reset mid-stream at D=7
    for (int n = 0; n < 10; n++) begin
      ce = 1'b1; valid_in = 1'b1; data_in = pat(400 + n);
      if (n == 0) begin
        delay_load = 1'b1; delay_in = 5'd7;
      end
      tick();
      delay_load = 1'b0;
    end
    check("t6_pre_valid", 128'(valid_out), 128'(1));
    check("t6_pre_data",  data_out,        pat(403));
    check("t6_pre_delay", 128'(delay_cur), 128'(7));
    check("t6_pre_err",   128'(cfg_err),   128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid",  128'(valid_out), 128'(0));
    check("t6_rst_delay",  128'(delay_cur), 128'(4));
    check("t6_rst_err",    128'(cfg_err),   128'(0));
    check("t6_rst_primed", 128'(primed),    128'(0));
`ifdef SRL_VAR_DELAY_RESET_DATA_EN
    check("t6_rst_data", data_out, 128'(0));
`endif
    #4 rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      ce = 1'b1; valid_in = 1'b1; data_in = pat(300 + n);
      tick();
      check("t6_valid",  128'(valid_out), 128'(n >= 3));
      check("t6_primed", 128'(primed),    128'(n >= 3));
      if (n >= 3) check("t6_data", data_out, pat(300 + n - 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
